// File: rtl/postnorm_pack_iter.sv
// Post-add normalize / round-to-nearest-even / IEEE-754 single pack stage of the iterative FP adder.
// Optional macro POSTNORM_FTZ_EN: flush denormal results to signed zero.
module postnorm_pack_iter #(
  parameter int SHIFT_STEP = 1  // max left-normalization shift per NORM cycle: 1, 2 or 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        SignIn,
  input  logic [7:0]  ExpIn,
  input  logic [27:0] SumM,
  input  logic [4:0]  ExcIn,
  input  logic        EffSub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Result,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE outside reset, out_valid stays high with Result stable
  // until out_ready is seen, and the stage holds at most one operation.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [27:0] m_q, m_d;
  logic [7:0]  e_q, e_d;
  logic        s_q, s_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] result_q, result_d;

  logic        is_nan;
  logic [2:0]  k;
  logic [27:0] m_norm;
  logic [7:0]  e_norm;
  logic        round_up;
  logic [24:0] rnd_sum;
  logic        rnd_carry;
  logic [27:0] m_rnd;
  logic [7:0]  e_rnd;

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign dbg_state = state_q;

  assign is_nan = ExcIn[3] | ExcIn[2] | (ExcIn[1] & ExcIn[0] & EffSub);

  // Shift amount grows only while the next bit is still zero and the exponent can absorb it.
  always_comb begin
    k = 3'd0;
    for (int i = 0; i < SHIFT_STEP; i++) begin
      if (k == 3'(i) && !m_q[26-i] && (int'(e_q) - 1) > i) k = 3'(i + 1);
    end
  end

  assign m_norm = m_q << k;
  assign e_norm = e_q - {5'b0, k};

  assign round_up  = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
  assign rnd_sum   = m_q[27:3] + 25'(round_up);
  assign rnd_carry = rnd_sum[24];
  assign m_rnd     = rnd_carry ? {1'b0, rnd_sum, m_q[2:1]} : {rnd_sum, m_q[2:0]};
  assign e_rnd     = rnd_carry ? e_q + 8'd1 : e_q;

  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    e_d         = e_q;
    s_d         = s_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (ExcIn[4]) begin
            state_d     = OUT;
            out_valid_d = 1'b1;
            result_d    = is_nan ? 32'h7FC0_0000 : {SignIn, 8'hFF, 23'h0};
          end else if (SumM == 28'h0) begin
            state_d     = OUT;
            out_valid_d = 1'b1;
            result_d    = {SignIn & ~EffSub, 31'h0};
          end else begin
            m_d = SumM;
            e_d = ExpIn;
            s_d = SignIn;
            // Operands that already need no normalization go straight to rounding.
            state_d = (SumM[27] || (!SumM[26] && ExpIn > 8'd1)) ? NORM : ROUND;
          end
        end
      end
      NORM: begin
        if (m_q[27]) begin
          m_d = {1'b0, m_q[27:2], m_q[1] | m_q[0]};
          e_d = e_q + 8'd1;
          if (e_q >= 8'hFE) begin
            state_d     = OUT;
            out_valid_d = 1'b1;
            result_d    = {s_q, 8'hFF, 23'h0};
          end else begin
            state_d = ROUND;
          end
        end else if (!m_q[26] && e_q > 8'd1) begin
          m_d = m_norm;
          e_d = e_norm;
          if (m_norm[26] || e_norm <= 8'd1) state_d = ROUND;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        state_d     = OUT;
        out_valid_d = 1'b1;
        m_d         = m_rnd;
        e_d         = e_rnd;
        if (rnd_carry && e_q >= 8'hFE) begin
          result_d = {s_q, 8'hFF, 23'h0};
        end else begin
`ifdef POSTNORM_FTZ_EN
          result_d = m_rnd[26] ? {s_q, e_rnd, m_rnd[25:3]} : {s_q, 31'h0};
`else
          // A denormal that rounds up into the hidden bit packs with exponent 1 naturally.
          result_d = {s_q, (m_rnd[26] ? e_rnd : 8'h00), m_rnd[25:3]};
`endif
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      m_q         <= 28'h0;
      e_q         <= 8'h0;
      s_q         <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      e_q         <= e_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

endmodule

// File: tb/tb_postnorm_pack_iter.sv
// Directed bench for postnorm_pack_iter: two instances (SHIFT_STEP 1 and 4) driven in lockstep.
module tb_postnorm_pack_iter;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_NORM = 2'd1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        SignIn;
  logic [7:0]  ExpIn;
  logic [27:0] SumM;
  logic [4:0]  ExcIn;
  logic        EffSub;
  logic        out_ready;

  logic        in_ready1, out_valid1, in_ready4, out_valid4;
  logic [31:0] result1, result4;
  logic [1:0]  state1, state4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  postnorm_pack_iter #(.SHIFT_STEP(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .SignIn(SignIn), .ExpIn(ExpIn), .SumM(SumM), .ExcIn(ExcIn), .EffSub(EffSub),
    .out_valid(out_valid1), .out_ready(out_ready), .Result(result1), .dbg_state(state1)
  );

  postnorm_pack_iter #(.SHIFT_STEP(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .SignIn(SignIn), .ExpIn(ExpIn), .SumM(SumM), .ExcIn(ExcIn), .EffSub(EffSub),
    .out_valid(out_valid4), .out_ready(out_ready), .Result(result4), .dbg_state(state4)
  );

  task automatic check(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Latency counts the accept edge as 1; out_valid is sampled 1ns after each edge.
  task automatic run_op(input logic sgn, input logic [7:0] ex, input logic [27:0] sm,
                        input logic [4:0] exc, input logic eff, input logic [31:0] exp_res,
                        input int lat1, input int lat4, input int hold, input string tag);
    int l1;
    int l4;
    int c;
    l1 = 0;
    l4 = 0;
    @(negedge clk);
    check({31'b0, in_ready1 & in_ready4}, 32'd1, {tag, "/in_ready"});
    SignIn   = sgn;
    ExpIn    = ex;
    SumM     = sm;
    ExcIn    = exc;
    EffSub   = eff;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    SumM     = 28'hFFF_FFFF;
    ExpIn    = 8'h55;
    c = 1;
    while ((l1 == 0 || l4 == 0) && c <= 40) begin
      if (l1 == 0 && out_valid1) l1 = c;
      if (l4 == 0 && out_valid4) l4 = c;
      if (l1 == 0 || l4 == 0) begin
        @(posedge clk);
        #1;
        c++;
      end
    end
    check(32'(l1), 32'(lat1), {tag, "/lat1"});
    check(32'(l4), 32'(lat4), {tag, "/lat4"});
    check(result1, exp_res, {tag, "/res1"});
    check(result4, exp_res, {tag, "/res4"});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({31'b0, out_valid1}, 32'd1, {tag, "/hold_valid"});
      check(result1, exp_res, {tag, "/hold_res"});
      check({31'b0, in_ready1}, 32'd0, {tag, "/hold_in_ready"});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({30'b0, out_valid1, out_valid4}, 32'd0, {tag, "/drained"});
    check({28'b0, state1, state4}, {28'b0, ST_IDLE, ST_IDLE}, {tag, "/idle"});
  endtask

  initial begin
    logic seen_valid;
    logic [31:0] exp_uf;
    logic [31:0] exp_den;
    rst       = 1'b1;
    in_valid  = 1'b0;
    SignIn    = 1'b0;
    ExpIn     = 8'h0;
    SumM      = 28'h0;
    ExcIn     = 5'h0;
    EffSub    = 1'b0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check({31'b0, out_valid1}, 32'd0, "rst/out_valid");
    check(result1, 32'h0, "rst/result1");
    check(result4, 32'h0, "rst/result4");
    check({30'b0, state1}, {30'b0, ST_IDLE}, "rst/state");
    check({31'b0, in_ready1}, 32'd0, "rst/in_ready_during");
    rst = 1'b0;
    #1;
    check({31'b0, in_ready1 & in_ready4}, 32'd1, "rst/in_ready_after");

    // Carry-out, normalization shifts and plain rounding.
    run_op(1'b0, 8'h7F, 28'h800_0000, 5'h00, 1'b0, 32'h4000_0000, 3, 3, 0, "one_plus_one");
    run_op(1'b0, 8'h7F, 28'h100_0000, 5'h00, 1'b1, 32'h3E80_0000, 4, 3, 0, "sub_shift2");
    run_op(1'b0, 8'h85, 28'h000_0100, 5'h00, 1'b1, 32'h3980_0000, 20, 7, 0, "sub_shift18");
    run_op(1'b0, 8'h7F, 28'h400_0004, 5'h00, 1'b0, 32'h3F80_0000, 2, 2, 0, "rne_tie_even");
    run_op(1'b0, 8'h7F, 28'h400_000C, 5'h00, 1'b0, 32'h3F80_0002, 2, 2, 5, "rne_tie_odd_hold");
    run_op(1'b0, 8'h7F, 28'h400_0005, 5'h00, 1'b0, 32'h3F80_0001, 2, 2, 0, "rne_above_half");
    run_op(1'b0, 8'h7F, 28'h7FF_FFFC, 5'h00, 1'b0, 32'h4000_0000, 2, 2, 0, "round_carry");

    // Exceptions and signed zero.
    run_op(1'b0, 8'h7F, 28'h400_0000, 5'b10011, 1'b1, 32'h7FC0_0000, 1, 1, 0, "inf_minus_inf");
    run_op(1'b1, 8'h7F, 28'h400_0000, 5'b10011, 1'b0, 32'hFF80_0000, 1, 1, 0, "neg_inf");
    run_op(1'b0, 8'h7F, 28'h400_0000, 5'b11000, 1'b0, 32'h7FC0_0000, 1, 1, 0, "nan_a");
    run_op(1'b1, 8'h7F, 28'h000_0000, 5'h00, 1'b1, 32'h0000_0000, 1, 1, 0, "zero_effsub");
    run_op(1'b1, 8'h7F, 28'h000_0000, 5'h00, 1'b0, 32'h8000_0000, 1, 1, 0, "zero_neg");

    // Overflow and underflow boundaries.
    run_op(1'b0, 8'hFE, 28'h800_0000, 5'h00, 1'b0, 32'h7F80_0000, 2, 2, 0, "ovf_carry");
    run_op(1'b0, 8'hFE, 28'h7FF_FFFC, 5'h00, 1'b0, 32'h7F80_0000, 2, 2, 0, "ovf_round");
    run_op(1'b0, 8'h01, 28'h3FF_FFFC, 5'h00, 1'b0, 32'h0080_0000, 2, 2, 0, "denorm_to_normal");
`ifdef POSTNORM_FTZ_EN
    exp_uf  = 32'h0000_0000;
    exp_den = 32'h8000_0000;
`else
    exp_uf  = 32'h0000_0001;
    exp_den = 32'h8020_0000;
`endif
    run_op(1'b0, 8'h01, 28'h000_0008, 5'h00, 1'b0, exp_uf, 2, 2, 0, "min_denorm");
    run_op(1'b1, 8'h03, 28'h040_0000, 5'h00, 1'b1, exp_den, 4, 3, 0, "shift_exp_limited");

    // Reset during NORM must abort with no result.
    @(negedge clk);
    ExpIn    = 8'h85;
    SumM     = 28'h000_0100;
    ExcIn    = 5'h00;
    SignIn   = 1'b0;
    EffSub   = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check({30'b0, state1}, {30'b0, ST_NORM}, "abort/in_norm");
    rst = 1'b1;
    @(posedge clk);
    #1;
    check({30'b0, out_valid1, out_valid4}, 32'd0, "abort/out_valid");
    check({28'b0, state1, state4}, {28'b0, ST_IDLE, ST_IDLE}, "abort/state");
    check({31'b0, in_ready1}, 32'd0, "abort/in_ready_during");
    rst = 1'b0;
    #1;
    check({31'b0, in_ready1 & in_ready4}, 32'd1, "abort/in_ready_after");
    seen_valid = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      seen_valid = seen_valid | out_valid1 | out_valid4;
    end
    check({31'b0, seen_valid}, 32'd0, "abort/no_result");
    run_op(1'b0, 8'h7F, 28'h800_0000, 5'h00, 1'b0, 32'h4000_0000, 3, 3, 0, "after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
